rr_arb_ctrl: RTL and testbench

//   Sequential controller for the round-robin arbiter. Samples the request vector, owns the rotating

---
 rtl/rr_arb_pkg.sv | 15 +
 rtl/priority_coder.sv | 20 ++
 rtl/rr_arb_ctrl.sv | 132 +++++++++++++
 tb/tb_rr_arb_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter controller.
package rr_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StGrant
  } state_t;

  // Pointer advance with wrap from n-1 back to 0.
  function automatic int unsigned next_ptr(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/priority_coder.sv
// Combinational index selector: prefers the prior_i slot, otherwise the highest set bit.
module priority_coder #(
  parameter int unsigned DATAWIDTH = 3
) (
  input  logic [2**DATAWIDTH-1:0] data_i,
  input  logic [DATAWIDTH-1:0]    prior_i,
  output logic [DATAWIDTH-1:0]    idx_o
);

  localparam int unsigned N = 2**DATAWIDTH;

  always_comb begin
    idx_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (data_i[k]) idx_o = DATAWIDTH'(k);
    end
    if (data_i[prior_i]) idx_o = prior_i;
  end

endmodule

// File: rtl/rr_arb_ctrl.sv
// Round-robin arbiter controller: snapshots requests, drives the coder, holds a registered grant.
// Optional grant-hold timeout enabled by defining ARB_TIMEOUT_EN.
module rr_arb_ctrl
  import rr_arb_pkg::*;
#(
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [2**IDX_W-1:0]   req_i,
  input  logic                  done_i,
  output logic                  gnt_vld_o,
  output logic [2**IDX_W-1:0]   gnt_o,
  output logic [IDX_W-1:0]      gnt_idx_o,
  output logic                  timeout_o
);

  localparam int unsigned N = 2**IDX_W;

  state_t           state_q, state_d;
  logic [N-1:0]     req_q, req_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] coder_idx;
  logic             timeout_hit;
  logic             release_grant;

  priority_coder #(
    .DATAWIDTH (IDX_W)
  ) u_coder (
    .data_i  (req_q),
    .prior_i (ptr_q),
    .idx_o   (coder_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned       HoldW    = $clog2(MAX_HOLD);
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(MAX_HOLD - 1);

  logic [HoldW-1:0] hold_q, hold_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) hold_q <= '0;
    else          hold_q <= hold_d;
  end

  // Saturates at the limit, which is also the cycle that forces the release.
  always_comb begin
    hold_d = hold_q;
    if (state_q == StArb) begin
      hold_d = '0;
    end else if (state_q == StGrant && hold_q != HoldLast) begin
      hold_d = hold_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == StGrant) && (hold_q == HoldLast);
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign timeout_hit     = 1'b0;
`endif

  assign release_grant = done_i | ~req_i[idx_q] | timeout_hit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      req_q     <= '0;
      gnt_q     <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      vld_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    vld_d     = vld_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          req_d   = req_i;
          state_d = StArb;
        end
      end
      StArb: begin
        idx_d            = coder_idx;
        gnt_d            = '0;
        gnt_d[coder_idx] = 1'b1;
        vld_d            = 1'b1;
        state_d          = StGrant;
      end
      StGrant: begin
        if (release_grant) begin
          vld_d     = 1'b0;
          gnt_d     = '0;
          ptr_d     = IDX_W'(next_ptr(32'(idx_q), N));
          timeout_d = timeout_hit;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_vld_o = vld_q;
    gnt_o     = gnt_q;
    gnt_idx_o = idx_q;
    timeout_o = timeout_q;
  end

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// Self-checking bench for rr_arb_ctrl: directed scenarios then random traffic vs a reference model.
module tb_rr_arb_ctrl;

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned N        = 8;
  localparam int unsigned MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n_i;
  logic [N-1:0]     req_i;
  logic             done_i;
  logic             gnt_vld_o;
  logic [N-1:0]     gnt_o;
  logic [IDX_W-1:0] gnt_idx_o;
  logic             timeout_o;

  rr_arb_ctrl #(
    .IDX_W    (IDX_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n_i),
    .req_i     (req_i),
    .done_i    (done_i),
    .gnt_vld_o (gnt_vld_o),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx_o),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model: phase 0 = waiting, 1 = choosing, 2 = granted.
  int           m_phase;
  int           m_ptr;
  int           m_idx;
  int           m_hold;
  logic [N-1:0] m_snap;
  logic         m_vld;
  logic         m_to;

  function automatic int pick(logic [N-1:0] r, int p);
    if (r[p]) return p;
    for (int i = N - 1; i >= 0; i--) begin
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_idx = 0; m_hold = 0;
    m_snap = '0; m_vld = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic d);
    bit tmo;
    m_to = 1'b0;
    case (m_phase)
      0: if (r != '0) begin
        m_snap  = r;
        m_phase = 1;
      end
      1: begin
        m_idx   = pick(m_snap, m_ptr);
        m_vld   = 1'b1;
        m_hold  = 0;
        m_phase = 2;
      end
      default: begin
        tmo = TO_EN && (m_hold == int'(MAX_HOLD) - 1);
        if (d || !r[m_idx] || tmo) begin
          m_vld   = 1'b0;
          m_ptr   = (m_idx + 1) % N;
          m_phase = 0;
          m_to    = tmo;
        end else if (m_hold < int'(MAX_HOLD) - 1) begin
          m_hold++;
        end
      end
    endcase
  endtask

  task automatic check(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_vld) eg[m_idx] = 1'b1;
    n_tests++;
    assert (gnt_vld_o === m_vld) else begin
      n_fail++;
      $error("FAIL %s gnt_vld observed=%0b expected=%0b", tag, gnt_vld_o, m_vld);
    end
    n_tests++;
    assert (gnt_o === eg) else begin
      n_fail++;
      $error("FAIL %s gnt observed=%02h expected=%02h", tag, gnt_o, eg);
    end
    n_tests++;
    assert (gnt_idx_o === 3'(m_idx)) else begin
      n_fail++;
      $error("FAIL %s gnt_idx observed=%0d expected=%0d", tag, gnt_idx_o, m_idx);
    end
    n_tests++;
    assert (timeout_o === m_to) else begin
      n_fail++;
      $error("FAIL %s timeout observed=%0b expected=%0b", tag, timeout_o, m_to);
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic d, input string tag);
    @(negedge clk);
    check(tag);
    req_i  = r;
    done_i = d;
    @(posedge clk);
    model_step(r, d);
  endtask

  task automatic expect_grant(input int idx);
    #1;
    n_tests++;
    assert (gnt_vld_o === 1'b1 && gnt_idx_o === 3'(idx)) else begin
      n_fail++;
      $error("FAIL grant_idx observed=%0b/%0d expected=1/%0d", gnt_vld_o, gnt_idx_o, idx);
    end
  endtask

  task automatic expect_idle();
    #1;
    n_tests++;
    assert (gnt_vld_o === 1'b0 && gnt_o === '0) else begin
      n_fail++;
      $error("FAIL released observed=%0b/%02h expected=0/00", gnt_vld_o, gnt_o);
    end
  endtask

  task automatic do_grant(input logic [N-1:0] r, input int idx);
    cyc(r, 1'b0, "req");
    cyc(r, 1'b0, "arb");
    expect_grant(idx);
    cyc(r, 1'b1, "done");
    expect_idle();
    cyc('0, 1'b0, "gap");
  endtask

  initial begin
    logic [N-1:0] r;
    logic         d;
    n_tests = 0;
    n_fail  = 0;
    rst_n_i = 1'b0;
    req_i   = '0;
    done_i  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;

    cyc('0, 1'b0, "reset");
    do_grant(8'h01, 0);           // grant at cycle 2, ptr -> 1
    do_grant(8'h80, 7);           // ptr 1 clear -> highest; wrap ptr -> 0
    do_grant(8'h06, 2);           // ptr 0 clear -> highest 2; ptr -> 3
    do_grant(8'h0A, 3);           // ptr -> 4
    do_grant(8'h80, 7);           // ptr -> 0
    do_grant(8'h81, 0);           // ptr -> 1

    // Dropped request releases; done plus drop advances the pointer once.
    cyc(8'h02, 1'b0, "drop_req");
    cyc(8'h02, 1'b0, "drop_arb");
    expect_grant(1);
    cyc(8'h00, 1'b0, "drop");
    expect_idle();
    cyc(8'h0C, 1'b0, "dd_req");
    cyc(8'h0C, 1'b0, "dd_arb");
    expect_grant(2);
    cyc(8'h00, 1'b1, "done_drop");
    expect_idle();
    do_grant(8'h88, 3);           // ptr 3 -> 3 wins, not 7; ptr -> 4

    // Continuously held requests: pointer moves past the previous grantee.
    cyc(8'hFF, 1'b0, "hold_req");
    cyc(8'hFF, 1'b0, "hold_arb");
    expect_grant(4);
    cyc(8'hFF, 1'b1, "hold_done");
    expect_idle();
    cyc(8'hFF, 1'b0, "hold_req2");
    cyc(8'hFF, 1'b0, "hold_arb2");
    expect_grant(5);
    cyc(8'h00, 1'b0, "hold_drop");
    expect_idle();

    // Request change during choosing is ignored; done outside a grant is ignored.
    cyc(8'h20, 1'b0, "snap_req");
    cyc(8'h01, 1'b1, "snap_arb");
    expect_grant(5);
    cyc(8'h00, 1'b0, "snap_rel");
    cyc(8'h00, 1'b1, "idle_done");

    // Long hold: held forever by default, periodic forced release with the timeout.
    for (int i = 0; i < 100; i++) cyc(8'h40, 1'b0, "long_hold");
    repeat (3) cyc(8'h00, 1'b0, "long_end");

    // Asynchronous reset in the middle of a grant.
    cyc(8'h40, 1'b0, "rst_req");
    cyc(8'h40, 1'b0, "rst_arb");
    expect_grant(6);
    #2;
    rst_n_i = 1'b0;
    #1;
    n_tests++;
    assert (gnt_vld_o === 1'b0 && gnt_o === '0 && timeout_o === 1'b0) else begin
      n_fail++;
      $error("FAIL async_reset observed=%0b/%02h expected=0/00", gnt_vld_o, gnt_o);
    end
    model_reset();
    req_i = '0;
    @(negedge clk);
    rst_n_i = 1'b1;
    do_grant(8'h10, 4);           // ptr back at 0: bit 0 clear -> highest 4

    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom) & N'($urandom);
      d = ($urandom_range(0, 4) == 0);
      cyc(r, d, "random");
    end
    cyc('0, 1'b0, "final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
